// File: rtl/snax_simbacore_out_packer.sv
// Packs Ratio narrow accelerator beats into one wide streamer word. A separate output
// register lets the next word fill while the previous one waits, giving one beat per cycle.
module snax_simbacore_out_packer #(
    parameter int InWidth  = 64,
    parameter int Ratio    = 4,
    parameter int CntWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CntWidth-1:0]      cfg_beats_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [InWidth-1:0]       acc_data_i,
    input  logic                     acc_valid_i,
    output logic                     acc_ready_o,
    output logic [InWidth*Ratio-1:0] stream_data_o,
    output logic [Ratio-1:0]         stream_strb_o,
    output logic                     stream_last_o,
    output logic                     stream_valid_o,
    input  logic                     stream_ready_i,
    output logic                     busy_o,
    output logic [CntWidth-1:0]      beat_cnt_o
);

    localparam int OutWidth  = InWidth * Ratio;
    localparam int LaneWidth = (Ratio > 1) ? $clog2(Ratio) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q;
    logic                 out_valid_q;
    logic [LaneWidth-1:0] lane_q;
    logic [CntWidth-1:0]  rem_q;
    logic [CntWidth-1:0]  beat_cnt_q;
    logic [OutWidth-1:0]  fill_q;
    logic [OutWidth-1:0]  out_data_q;
    logic [Ratio-1:0]     strb_q;
    logic                 last_q;

    logic                 final_beat;
    logic                 completing;
    logic                 cfg_fire;
    logic                 acc_fire;
    logic                 stream_fire;
    logic [OutWidth-1:0]  packed_word;
    logic [Ratio-1:0]     strb_next;

    assign final_beat  = (rem_q == CntWidth'(1));
    assign completing  = (lane_q == LaneWidth'(Ratio - 1)) || final_beat;

    assign cfg_ready_o = (state_q == IDLE);
    // A completing beat may only enter when the output register is free or drains this cycle.
    assign acc_ready_o = (state_q == RUN) && (!completing || !out_valid_q || stream_ready_i);

    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign acc_fire    = acc_valid_i && acc_ready_o;
    assign stream_fire = out_valid_q && stream_ready_i;

    // Word to load on a completing beat: current beat in its lane, lanes above it cleared.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        packed_word = fill_q;
        strb_next   = '0;
        for (int k = 0; k < Ratio; k++) begin
            if (LaneWidth'(k) == lane_q) begin
                packed_word[k*InWidth +: InWidth] = acc_data_i;
            end else if (LaneWidth'(k) > lane_q) begin
                packed_word[k*InWidth +: InWidth] = '0;
            end
            strb_next[k] = (LaneWidth'(k) <= lane_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            lane_q      <= '0;
            rem_q       <= '0;
            beat_cnt_q  <= '0;
            // NOTE: the wide data registers are reset too, so stale lanes never leak after a reset.
            fill_q      <= '0;
            out_data_q  <= '0;
            strb_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_fire) begin
                        beat_cnt_q <= '0;
                        if (cfg_beats_i != '0) begin
                            rem_q   <= cfg_beats_i;
                            lane_q  <= '0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (acc_fire) begin
                        rem_q      <= rem_q - CntWidth'(1);
                        beat_cnt_q <= beat_cnt_q + CntWidth'(1);
                        if (completing) begin
                            fill_q <= '0;
                            lane_q <= '0;
                            if (final_beat) begin
                                state_q <= DONE;
                            end
                        end else begin
                            fill_q[lane_q*InWidth +: InWidth] <= acc_data_i;
                            lane_q <= lane_q + LaneWidth'(1);
                        end
                    end
                end
                DONE: begin
                    if (stream_fire || !out_valid_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Reload wins over drain, so a word leaving and a word arriving share one cycle.
            if (acc_fire && completing) begin
                out_data_q  <= packed_word;
                strb_q      <= strb_next;
                last_q      <= final_beat;
                out_valid_q <= 1'b1;
            end else if (stream_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign stream_data_o  = out_data_q;
    assign stream_strb_o  = strb_q;
    assign stream_last_o  = last_q;
    assign stream_valid_o = out_valid_q;
    assign busy_o         = (state_q != IDLE) || out_valid_q;
    assign beat_cnt_o     = beat_cnt_q;

endmodule

// File: tb/tb_snax_simbacore_out_packer.sv
// Directed bench for snax_simbacore_out_packer: a per-cycle vector table for two plain jobs,
// then hand-written sequences for backpressure, empty jobs, mid-job reset and held configs.
module tb_snax_simbacore_out_packer;

    localparam int InWidth  = 64;
    localparam int Ratio    = 4;
    localparam int CntWidth = 32;
    localparam int OutWidth = InWidth * Ratio;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [CntWidth-1:0] cfg_beats_i;
    logic                cfg_valid_i;
    logic                cfg_ready_o;
    logic [InWidth-1:0]  acc_data_i;
    logic                acc_valid_i;
    logic                acc_ready_o;
    logic [OutWidth-1:0] stream_data_o;
    logic [Ratio-1:0]    stream_strb_o;
    logic                stream_last_o;
    logic                stream_valid_o;
    logic                stream_ready_i;
    logic                busy_o;
    logic [CntWidth-1:0] beat_cnt_o;

    snax_simbacore_out_packer #(
        .InWidth (InWidth),
        .Ratio   (Ratio),
        .CntWidth(CntWidth)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_beats_i   (cfg_beats_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .acc_data_i    (acc_data_i),
        .acc_valid_i   (acc_valid_i),
        .acc_ready_o   (acc_ready_o),
        .stream_data_o (stream_data_o),
        .stream_strb_o (stream_strb_o),
        .stream_last_o (stream_last_o),
        .stream_valid_o(stream_valid_o),
        .stream_ready_i(stream_ready_i),
        .busy_o        (busy_o),
        .beat_cnt_o    (beat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [OutWidth-1:0] act, input logic [OutWidth-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic                cfg_v;
        logic [CntWidth-1:0] beats;
        logic                acc_v;
        logic [InWidth-1:0]  acc_d;
        logic                s_rdy;
        logic                e_cfg_rdy;
        logic                e_acc_rdy;
        logic                e_sv;
        logic [OutWidth-1:0] e_data;
        logic [Ratio-1:0]    e_strb;
        logic                e_last;
        logic                e_busy;
        logic [CntWidth-1:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic cv, input int b, input logic av, input int ad, input logic sr,
                                input logic ecr, input logic ear, input logic esv, input logic [OutWidth-1:0] ed,
                                input logic [Ratio-1:0] es, input logic el, input logic eb, input int ec);
        vec_t v;
        v.cfg_v = cv;  v.beats = CntWidth'(b); v.acc_v = av; v.acc_d = InWidth'(ad); v.s_rdy = sr;
        v.e_cfg_rdy = ecr; v.e_acc_rdy = ear; v.e_sv = esv; v.e_data = ed; v.e_strb = es;
        v.e_last = el; v.e_busy = eb; v.e_cnt = CntWidth'(ec);
        return v;
    endfunction

    localparam logic [OutWidth-1:0] W1234 = {64'd4, 64'd3, 64'd2, 64'd1};
    localparam logic [OutWidth-1:0] W5678 = {64'd8, 64'd7, 64'd6, 64'd5};
    localparam logic [OutWidth-1:0] W56   = {64'd0, 64'd0, 64'd6, 64'd5};
    localparam logic [OutWidth-1:0] W9    = {64'd12, 64'd11, 64'd10, 64'd9};
    localparam logic [OutWidth-1:0] W21   = {64'd0, 64'd23, 64'd22, 64'd21};

    vec_t vecs[19];

    logic [OutWidth-1:0] words[$];
    logic [Ratio-1:0]    strbs[$];
    logic                lasts[$];
    int                  fire_cyc[$];

    // Drives n beats first, first+1, ... with the streamer always ready and logs every word seen.
    task automatic run_feed(input int n, input logic [InWidth-1:0] first, input int max_cycles);
        int sent = 0;
        stream_ready_i = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            acc_valid_i = (sent < n);
            acc_data_i  = first + InWidth'(sent);
            #1;
            if (stream_valid_o) begin
                words.push_back(stream_data_o);
                strbs.push_back(stream_strb_o);
                lasts.push_back(stream_last_o);
            end
            if (acc_valid_i && acc_ready_o) sent++;
            @(negedge clk_i);
        end
        acc_valid_i = 1'b0;
        check("feed_beats_accepted", OutWidth'(sent), OutWidth'(n));
    endtask

    task automatic cfg_job(input int beats);
        cfg_valid_i = 1'b1;
        cfg_beats_i = CntWidth'(beats);
        #1;
        check("cfg_ready_idle", cfg_ready_o, 1'b1);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic                held;
        logic [OutWidth-1:0] held_data;
        int                  stable_err;
        int                  held_cycles;
        int                  next;
        int                  n_stalled;
        int                  acc_cycle;
        int                  nwords;
        logic                got;

        //            cfg beats acc data rdy | crdy ardy sv data   strb  last busy cnt
        vecs[0]  = mk(1, 8, 0, 0, 1,   1, 0, 0, '0,    4'h0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 1, 1,   0, 1, 0, '0,    4'h0, 0, 1, 0);
        vecs[2]  = mk(0, 0, 1, 2, 1,   0, 1, 0, '0,    4'h0, 0, 1, 1);
        vecs[3]  = mk(0, 0, 1, 3, 1,   0, 1, 0, '0,    4'h0, 0, 1, 2);
        vecs[4]  = mk(0, 0, 1, 4, 1,   0, 1, 0, '0,    4'h0, 0, 1, 3);
        vecs[5]  = mk(0, 0, 1, 5, 1,   0, 1, 1, W1234, 4'hF, 0, 1, 4);
        vecs[6]  = mk(0, 0, 1, 6, 1,   0, 1, 0, '0,    4'h0, 0, 1, 5);
        vecs[7]  = mk(0, 0, 1, 7, 1,   0, 1, 0, '0,    4'h0, 0, 1, 6);
        vecs[8]  = mk(0, 0, 1, 8, 1,   0, 1, 0, '0,    4'h0, 0, 1, 7);
        vecs[9]  = mk(0, 0, 0, 0, 1,   0, 0, 1, W5678, 4'hF, 1, 1, 8);
        vecs[10] = mk(1, 6, 0, 0, 1,   1, 0, 0, '0,    4'h0, 0, 0, 8);
        vecs[11] = mk(0, 0, 1, 1, 1,   0, 1, 0, '0,    4'h0, 0, 1, 0);
        vecs[12] = mk(0, 0, 1, 2, 1,   0, 1, 0, '0,    4'h0, 0, 1, 1);
        vecs[13] = mk(0, 0, 1, 3, 1,   0, 1, 0, '0,    4'h0, 0, 1, 2);
        vecs[14] = mk(0, 0, 1, 4, 1,   0, 1, 0, '0,    4'h0, 0, 1, 3);
        vecs[15] = mk(0, 0, 1, 5, 1,   0, 1, 1, W1234, 4'hF, 0, 1, 4);
        vecs[16] = mk(0, 0, 1, 6, 1,   0, 1, 0, '0,    4'h0, 0, 1, 5);
        vecs[17] = mk(0, 0, 0, 0, 1,   0, 0, 1, W56,   4'h3, 1, 1, 6);
        vecs[18] = mk(0, 0, 0, 0, 1,   1, 0, 0, '0,    4'h0, 0, 0, 6);

        rst_i = 1'b1;
        cfg_valid_i = 1'b0; cfg_beats_i = '0;
        acc_valid_i = 1'b0; acc_data_i = '0;
        stream_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_valid", stream_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_cnt", beat_cnt_o, '0);
        check("rst_strb_last", {stream_strb_o, stream_last_o}, '0);
        check("rst_data", stream_data_o, '0);
        rst_i = 1'b0;

        // Table: beats=8 then beats=6 with the streamer always ready.
        for (int i = 0; i < 19; i++) begin
            cfg_valid_i    = vecs[i].cfg_v;
            cfg_beats_i    = vecs[i].beats;
            acc_valid_i    = vecs[i].acc_v;
            acc_data_i     = vecs[i].acc_d;
            stream_ready_i = vecs[i].s_rdy;
            #1;
            check($sformatf("v%0d_cfg_ready", i), cfg_ready_o, vecs[i].e_cfg_rdy);
            check($sformatf("v%0d_acc_ready", i), acc_ready_o, vecs[i].e_acc_rdy);
            check($sformatf("v%0d_valid", i), stream_valid_o, vecs[i].e_sv);
            check($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
            check($sformatf("v%0d_cnt", i), beat_cnt_o, vecs[i].e_cnt);
            if (vecs[i].e_sv) begin
                check($sformatf("v%0d_data", i), stream_data_o, vecs[i].e_data);
                check($sformatf("v%0d_strb", i), stream_strb_o, vecs[i].e_strb);
                check($sformatf("v%0d_last", i), stream_last_o, vecs[i].e_last);
            end
            @(negedge clk_i);
        end
        cfg_valid_i = 1'b0;

        // Backpressure: streamer stalled until cycle 10 of a beats=8 job.
        cfg_job(8);
        next = 1; n_stalled = 0; held = 1'b0; held_data = '0; stable_err = 0; held_cycles = 0;
        words.delete(); lasts.delete(); fire_cyc.delete();
        for (int c = 1; c < 40; c++) begin
            stream_ready_i = (c >= 10);
            acc_valid_i    = (next <= 8);
            acc_data_i     = InWidth'(next);
            #1;
            if (c == 9) check("bp_completing_beat_blocked", acc_ready_o, 1'b0);
            if (held) begin
                held_cycles++;
                if (!stream_valid_o || stream_data_o !== held_data) stable_err++;
            end
            if (acc_valid_i && acc_ready_o) begin
                if (c < 10) n_stalled++;
                next++;
            end
            if (stream_valid_o && stream_ready_i) begin
                words.push_back(stream_data_o);
                lasts.push_back(stream_last_o);
                fire_cyc.push_back(c);
            end
            held      = stream_valid_o && !stream_ready_i;
            held_data = stream_data_o;
            @(negedge clk_i);
            if (words.size() == 2 && !busy_o) break;
        end
        acc_valid_i = 1'b0;
        check("bp_beats_before_release", OutWidth'(n_stalled), OutWidth'(7));
        check("bp_word_count", OutWidth'(words.size()), OutWidth'(2));
        check("bp_held_cycles", OutWidth'(held_cycles), OutWidth'(5));
        check("bp_word_stable", OutWidth'(stable_err), '0);
        if (words.size() == 2) begin
            check("bp_word0", words[0], W1234);
            check("bp_word1", words[1], W5678);
            check("bp_lasts", {lasts[0], lasts[1]}, 2'b01);
            check("bp_no_bubble", OutWidth'(fire_cyc[1] - fire_cyc[0]), OutWidth'(1));
        end
        check("bp_cnt", beat_cnt_o, OutWidth'(8));

        // Empty job: accepted at once, nothing emitted, counter cleared.
        cfg_valid_i = 1'b1; cfg_beats_i = '0; acc_valid_i = 1'b1; acc_data_i = 64'hDEAD;
        #1;
        check("zero_cfg_ready", cfg_ready_o, 1'b1);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("zero_acc_ready", acc_ready_o, 1'b0);
            check("zero_valid_busy", {stream_valid_o, busy_o}, 2'b00);
            @(negedge clk_i);
        end
        check("zero_cnt", beat_cnt_o, '0);
        acc_valid_i = 1'b0;

        // Reset after 2 of 8 beats drops everything; a later 4-beat job yields one last word.
        cfg_job(8);
        words.delete(); strbs.delete(); lasts.delete();
        run_feed(2, 64'd1, 2);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("mrst_valid_busy", {stream_valid_o, busy_o}, 2'b00);
        check("mrst_cnt", beat_cnt_o, '0);
        check("mrst_ready", {cfg_ready_o, acc_ready_o}, 2'b10);
        check("mrst_data", stream_data_o, '0);
        check("mrst_strb_last", {stream_strb_o, stream_last_o}, '0);
        @(negedge clk_i);
        run_feed(0, 64'd0, 5);
        check("mrst_no_word", OutWidth'(words.size()), '0);
        cfg_job(4);
        run_feed(4, 64'd9, 10);
        nwords = words.size();
        check("mrst_one_word", OutWidth'(nwords), OutWidth'(1));
        if (nwords == 1) begin
            check("mrst_word", words[0], W9);
            check("mrst_strb_last", {strbs[0], lasts[0]}, 5'b11111);
        end

        // Config held during a job is only accepted once the block is idle again.
        cfg_job(2);
        cfg_valid_i = 1'b1; cfg_beats_i = 32'd3;
        next = 1; acc_cycle = -1;
        for (int c = 1; c < 20; c++) begin
            acc_valid_i    = (next <= 2);
            acc_data_i     = InWidth'(next);
            stream_ready_i = 1'b1;
            #1;
            if (busy_o) check("held_cfg_not_ready", cfg_ready_o, 1'b0);
            if (acc_valid_i && acc_ready_o) next++;
            got = cfg_ready_o;
            @(negedge clk_i);
            if (got) begin
                acc_cycle = c;
                break;
            end
        end
        cfg_valid_i = 1'b0;
        acc_valid_i = 1'b0;
        check("held_cfg_accept_cycle", OutWidth'(acc_cycle), OutWidth'(4));
        words.delete(); strbs.delete(); lasts.delete();
        run_feed(3, 64'd21, 8);
        nwords = words.size();
        check("held_job_words", OutWidth'(nwords), OutWidth'(1));
        if (nwords == 1) begin
            check("held_job_word", words[0], W21);
            check("held_job_strb_last", {strbs[0], lasts[0]}, 5'b01111);
        end
        check("held_job_cnt", beat_cnt_o, OutWidth'(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
